// File: rtl/mips_mem_pkg.sv
// Shared types for the unified MIPS memory port: arbiter FSM states and requester IDs.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

endpackage : mips_mem_pkg

// File: rtl/mem_arb_pick.sv
// Combinational winner select between CPU and DMA requesters.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed CPU-first priority.
module mem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic    i_cpu_req,
    input  logic    i_dma_req,
    input  req_id_e i_last,
    output logic    o_any_c,
    output req_id_e o_win_c
);

    assign o_any_c = i_cpu_req | i_dma_req;

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first.
    always_comb begin
        o_win_c = REQ_CPU;
        if (i_cpu_req && i_dma_req) begin
            o_win_c = (i_last == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (i_dma_req) begin
            o_win_c = REQ_DMA;
        end
    end
`else
    // History is irrelevant under fixed priority.
    logic w_unused_c;
    assign w_unused_c = (i_last == REQ_DMA);

    always_comb begin
        o_win_c = REQ_CPU;
        if (i_dma_req && !i_cpu_req) begin
            o_win_c = REQ_DMA;
        end
    end
`endif

endmodule : mem_arb_pick

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle MIPS core (CPU control path vs DMA/debug loader).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 2      // must be >= 1
) (
    input  logic          cclk,
    input  logic          rstb,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          cpu_gnt,
    output logic          dma_gnt,
    output logic          cpu_rvalid,
    output logic          dma_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    arb_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    req_id_e       r_owner, w_owner_nxt;
    logic          r_mem_en, w_mem_en_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_rdata, w_rdata_nxt;
    logic          r_cpu_gnt, w_cpu_gnt_nxt;
    logic          r_dma_gnt, w_dma_gnt_nxt;
    logic          r_cpu_rvalid, w_cpu_rvalid_nxt;
    logic          r_dma_rvalid, w_dma_rvalid_nxt;

    logic          w_any_c;
    req_id_e       w_win_c;

    // The owner register also serves as the last-winner history for round-robin.
    mem_arb_pick u_pick (
        .i_cpu_req (cpu_req),
        .i_dma_req (dma_req),
        .i_last    (r_owner),
        .o_any_c   (w_any_c),
        .o_win_c   (w_win_c)
    );

    // Next-state and next-output logic; strobes are computed one cycle ahead and registered.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_rdata_nxt      = r_rdata;
        w_cpu_gnt_nxt    = 1'b0;
        w_dma_gnt_nxt    = 1'b0;
        w_cpu_rvalid_nxt = 1'b0;
        w_dma_rvalid_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_any_c) begin
                    w_state_nxt  = ISSUE;
                    w_owner_nxt  = w_win_c;
                    w_mem_en_nxt = 1'b1;
                    if (w_win_c == REQ_DMA) begin
                        w_mem_we_nxt    = dma_we;
                        w_mem_addr_nxt  = dma_addr;
                        w_mem_wdata_nxt = dma_wdata;
                        w_dma_gnt_nxt   = 1'b1;
                    end else begin
                        w_mem_we_nxt    = cpu_we;
                        w_mem_addr_nxt  = cpu_addr;
                        w_mem_wdata_nxt = cpu_wdata;
                        w_cpu_gnt_nxt   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (r_mem_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = CW'(MEM_LAT - 1);
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt = mem_rdata;
                    w_state_nxt = RESP;
                    if (r_owner == REQ_DMA) begin
                        w_dma_rvalid_nxt = 1'b1;
                    end else begin
                        w_cpu_rvalid_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= REQ_DMA;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_rdata      <= w_rdata_nxt;
            r_cpu_gnt    <= w_cpu_gnt_nxt;
            r_dma_gnt    <= w_dma_gnt_nxt;
            r_cpu_rvalid <= w_cpu_rvalid_nxt;
            r_dma_rvalid <= w_dma_rvalid_nxt;
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign dma_gnt    = r_dma_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_rdata;
    assign dma_rdata  = r_rdata;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic cclk = 1'b0;
    logic rstb = 1'b1;
    always #5 cclk = ~cclk;

    // MEM_LAT=2 instance
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0, mem_rdata = '0;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_en, mem_we;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    // MEM_LAT=1 instance
    logic          cpu_req1 = 1'b0, cpu_we1 = 1'b0, dma_req1 = 1'b0, dma_we1 = 1'b0;
    logic [AW-1:0] cpu_addr1 = '0, dma_addr1 = '0;
    logic [DW-1:0] cpu_wdata1 = '0, dma_wdata1 = '0, mem_rdata1 = '0;
    logic          cpu_gnt1, dma_gnt1, cpu_rvalid1, dma_rvalid1, mem_en1, mem_we1;
    logic [DW-1:0] cpu_rdata1, dma_rdata1, mem_wdata1;
    logic [AW-1:0] mem_addr1;

    // {mem_en, mem_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}
    wire [5:0] w_flags  = {mem_en, mem_we, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid};
    wire [5:0] w_flags1 = {mem_en1, mem_we1, cpu_gnt1, dma_gnt1, cpu_rvalid1, dma_rvalid1};

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) u_dut (
        .cclk(cclk), .rstb(rstb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut1 (
        .cclk(cclk), .rstb(rstb),
        .cpu_req(cpu_req1), .cpu_we(cpu_we1), .cpu_addr(cpu_addr1), .cpu_wdata(cpu_wdata1),
        .dma_req(dma_req1), .dma_we(dma_we1), .dma_addr(dma_addr1), .dma_wdata(dma_wdata1),
        .cpu_gnt(cpu_gnt1), .dma_gnt(dma_gnt1), .cpu_rvalid(cpu_rvalid1), .dma_rvalid(dma_rvalid1),
        .cpu_rdata(cpu_rdata1), .dma_rdata(dma_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    task automatic tick;
        @(posedge cclk);
        #1;
    endtask

    task automatic test_reset;
        #2 rstb = 1'b0;
        #10;
        n_cmp++;
        if ({w_flags, w_flags1} !== 12'h000) begin
            n_err++; $display("FAIL reset_flags: got %b required 000000000000", {w_flags, w_flags1});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h required all zero", {mem_addr, mem_wdata, cpu_rdata, dma_rdata});
        end
        n_cmp++;
        if ({mem_addr1, mem_wdata1, cpu_rdata1, dma_rdata1} !== 128'h0) begin
            n_err++; $display("FAIL reset_data1: got %h required all zero", {mem_addr1, mem_wdata1, cpu_rdata1, dma_rdata1});
        end
        @(negedge cclk) rstb = 1'b1;
        tick();
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL idle_after_reset: got %b required 000000", w_flags);
        end
    endtask

    task automatic test_cpu_read;
        cpu_addr = 32'h40; cpu_we = 1'b0; cpu_req = 1'b1; mem_rdata = 32'hBAD0_0001;
        tick(); // cycle 1: ISSUE
        n_cmp++;
        if ({w_flags, mem_addr} !== {6'b101000, 32'h40}) begin
            n_err++; $display("FAIL rd_issue: got flags %b addr %h required 101000 00000040", w_flags, mem_addr);
        end
        cpu_req = 1'b0; mem_rdata = 32'hBAD0_0002;
        tick(); // cycle 2: WAIT
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL rd_wait1: got %b required 000000", w_flags);
        end
        tick(); // cycle 3: WAIT, data valid now
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL rd_wait2: got %b required 000000", w_flags);
        end
        mem_rdata = 32'h1234ABCD;
        tick(); // cycle 4: RESP
        mem_rdata = 32'hBAD0_0004;
        n_cmp++;
        if ({w_flags, cpu_rdata, dma_rdata} !== {6'b000010, 32'h1234ABCD, 32'h1234ABCD}) begin
            n_err++; $display("FAIL rd_resp: got flags %b cpu %h dma %h required 000010 1234abcd 1234abcd",
                              w_flags, cpu_rdata, dma_rdata);
        end
        tick(); // cycle 5: IDLE
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL rd_done: got %b required 000000", w_flags);
        end
    endtask

    task automatic test_dma_write;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if ({w_flags, mem_addr, mem_wdata} !== {6'b110100, 32'h80, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_issue: got flags %b addr %h data %h required 110100 00000080 deadbeef",
                              w_flags, mem_addr, mem_wdata);
        end
        dma_req = 1'b0;
        tick(); // IDLE again; a request now must be accepted at this cycle's edge
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL wr_idle: got %b required 000000", w_flags);
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h11;
        tick();
        n_cmp++;
        if ({w_flags, mem_addr, mem_wdata} !== {6'b111000, 32'h44, 32'h11}) begin
            n_err++; $display("FAIL wr_next: got flags %b addr %h data %h required 111000 00000044 00000011",
                              w_flags, mem_addr, mem_wdata);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (w_flags !== 6'b000000) begin
            n_err++; $display("FAIL wr_no_rvalid: got %b required 000000", w_flags);
        end
    endtask

    task automatic test_priority;
        logic [3:0] seq;
        logic [3:0] exp_seq;
        int         n_got;
        int         first_c;
        int         last_c;
        logic       bad;
`ifdef MEM_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        seq = '0; n_got = 0; first_c = -1; last_c = -1; bad = 1'b0;
        @(negedge cclk) rstb = 1'b0;
        @(negedge cclk) rstb = 1'b1;
        cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0;
        dma_we = 1'b1; dma_addr = 32'h200; dma_wdata = 32'hD0;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int c = 0; c < 20 && n_got < 4; c++) begin
            tick();
            if (cpu_gnt && dma_gnt) bad = 1'b1;
            if (cpu_gnt || dma_gnt) begin
                seq[n_got] = dma_gnt;
                if (mem_addr !== (dma_gnt ? 32'h200 : 32'h100)) bad = 1'b1;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_got++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        n_cmp++;
        if (n_got !== 4) begin
            n_err++; $display("FAIL arb_count: got %0d grants required 4", n_got);
        end
        n_cmp++;
        if (seq !== exp_seq) begin
            n_err++; $display("FAIL arb_order: got %b required %b (bit k = grant k went to DMA)", seq, exp_seq);
        end
        n_cmp++;
        if ({bad, first_c[7:0], last_c[7:0]} !== {1'b0, 8'd0, 8'd6}) begin
            n_err++; $display("FAIL arb_timing: got bad=%b first=%0d last=%0d required bad=0 first=0 last=6",
                              bad, first_c, last_c);
        end
        tick();
        tick();
    endtask

    task automatic test_wait_overlap;
        logic [1:0] exp;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h60; mem_rdata = 32'h5555AAAA;
        tick(); // cycle 1: ISSUE
        n_cmp++;
        if (w_flags !== 6'b101000) begin
            n_err++; $display("FAIL ovl_issue: got %b required 101000", w_flags);
        end
        cpu_req = 1'b0;
        tick(); // cycle 2: WAIT, DMA arrives
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h90; dma_wdata = 32'h77;
        for (int c = 3; c <= 7; c++) begin
            tick();
            exp = (c == 4) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({cpu_rvalid, dma_gnt} !== exp) begin
                n_err++; $display("FAIL ovl_cycle%0d: got {cpu_rvalid,dma_gnt}=%b required %b",
                                  c, {cpu_rvalid, dma_gnt}, exp);
            end
            if (c == 6) dma_req = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset_mid;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h70; cpu_wdata = 32'h99;
        mem_rdata = 32'h0F0F0F0F;
        tick(); // ISSUE
        cpu_req = 1'b0;
        tick(); // WAIT
        #2 rstb = 1'b0;
        #1;
        n_cmp++;
        if ({w_flags, mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== {6'b0, 128'h0}) begin
            n_err++; $display("FAIL rst_mid: got flags %b addr %h wdata %h rdata %h required all zero",
                              w_flags, mem_addr, mem_wdata, cpu_rdata);
        end
        @(negedge cclk);
        @(negedge cclk) rstb = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (w_flags !== 6'b000000) begin
                n_err++; $display("FAIL rst_quiet%0d: got %b required 000000", c, w_flags);
            end
        end
        cpu_req = 1'b1; cpu_addr = 32'h74;
        tick();
        n_cmp++;
        if ({w_flags, mem_addr} !== {6'b101000, 32'h74}) begin
            n_err++; $display("FAIL rst_after_issue: got flags %b addr %h required 101000 00000074", w_flags, mem_addr);
        end
        cpu_req = 1'b0;
        tick();
        tick();
        tick();
        n_cmp++;
        if ({w_flags, cpu_rdata} !== {6'b000010, 32'h0F0F0F0F}) begin
            n_err++; $display("FAIL rst_after_resp: got flags %b rdata %h required 000010 0f0f0f0f", w_flags, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_lat1;
        cpu_req1 = 1'b1; cpu_we1 = 1'b0; cpu_addr1 = 32'h30; mem_rdata1 = 32'hBAD1_0001;
        tick(); // N+1: ISSUE
        n_cmp++;
        if ({w_flags1, mem_addr1} !== {6'b101000, 32'h30}) begin
            n_err++; $display("FAIL lat1_issue: got flags %b addr %h required 101000 00000030", w_flags1, mem_addr1);
        end
        cpu_req1 = 1'b0;
        tick(); // N+2: WAIT, data valid
        n_cmp++;
        if (w_flags1 !== 6'b000000) begin
            n_err++; $display("FAIL lat1_wait: got %b required 000000", w_flags1);
        end
        mem_rdata1 = 32'hCAFEF00D;
        tick(); // N+3: RESP
        mem_rdata1 = 32'hBAD1_0003;
        n_cmp++;
        if ({w_flags1, cpu_rdata1} !== {6'b000010, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL lat1_resp: got flags %b rdata %h required 000010 cafef00d", w_flags1, cpu_rdata1);
        end
        tick();
        n_cmp++;
        if (w_flags1 !== 6'b000000) begin
            n_err++; $display("FAIL lat1_done: got %b required 000000", w_flags1);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_priority();
        test_wait_overlap();
        test_reset_mid();
        test_lat1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_mem_port_arbiter
